// File: rtl/casu_pkg.sv
// Shared encodings for the CASU executable-region update controller:
// FSM states, error codes, register offsets and CTRL/STAT bit positions.
package casu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_WAIT_AUTH = 3'd2,
    ST_COMMIT    = 3'd3
  } casu_state_e;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_RANGE     = 3'd1;
  localparam logic [2:0] ERR_ORDER     = 3'd2;
  localparam logic [2:0] ERR_AUTH_FAIL = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd4;
  localparam logic [2:0] ERR_ABORT     = 3'd5;
  localparam logic [2:0] ERR_LOCKED    = 3'd6;

  localparam logic [1:0] OFF_STG_MIN = 2'd0;
  localparam logic [1:0] OFF_STG_MAX = 2'd1;
  localparam logic [1:0] OFF_CTRL    = 2'd2;
  localparam logic [1:0] OFF_STAT    = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_ERR_LSB   = 4;
  localparam int STAT_DONE_BIT  = 8;
  localparam int STAT_REQ_BIT   = 9;
  localparam int STAT_LOCK_BIT  = 10;

  function automatic logic [15:0] pack_stat(input casu_state_e st, input logic [2:0] err,
                                            input logic done, input logic req, input logic lock);
    logic [15:0] w;
    w = 16'h0000;
    w[STAT_STATE_LSB +: 3] = st;
    w[STAT_ERR_LSB +: 3]   = err;
    w[STAT_DONE_BIT]       = done;
    w[STAT_REQ_BIT]        = req;
    w[STAT_LOCK_BIT]       = lock;
    return w;
  endfunction

endpackage

// File: rtl/casu_er_check.sv
// Combinational validator for staged ER bounds: window range first, then
// ordering and alignment (ER_min even, ER_max odd).
module casu_er_check
  import casu_pkg::*;
(
  input  logic [15:0] stg_min,
  input  logic [15:0] stg_max,
  input  logic [15:0] win_lo,
  input  logic [15:0] win_hi,
  output logic [2:0]  err
);

  // Range violations take precedence over order/alignment violations
  always_comb begin
    err = ERR_NONE;
    if ((stg_min < win_lo) || (stg_max > win_hi)) begin
      err = ERR_RANGE;
    end else if ((stg_min > stg_max) || stg_min[0] || !stg_max[0]) begin
      err = ERR_ORDER;
    end else begin
      err = ERR_NONE;
    end
  end

endmodule

// File: rtl/casu_er_update_ctrl.sv
// Authenticated atomic update of CASU ER_min/ER_max on the openMSP430 peripheral bus.
// Optional one-shot lock after the first commit: define CASU_ER_LOCK_EN.
module casu_er_update_ctrl
  import casu_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0078,
  parameter int          DEC_WD    = 2,
  parameter logic [15:0] WIN_LO    = 16'hC000,
  parameter logic [15:0] WIN_HI    = 16'hEFFF,
  parameter logic [15:0] RST_MIN   = 16'hE000,
  parameter logic [15:0] RST_MAX   = 16'hEFFF,
  parameter int          AUTH_TO   = 1024
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        auth_ok,
  input  logic        auth_fail,
  output logic        auth_req,
  output logic [15:0] ER_min,
  output logic [15:0] ER_max,
  output logic        upd_busy
);

  localparam logic [15:0] TO_LAST = 16'(AUTH_TO - 1);

  casu_state_e       state_r;
  logic [15:0]       stg_min_r, stg_max_r, er_min_r, er_max_r, to_cnt_r;
  logic [2:0]        err_r, chk_err_s;
  logic              done_r, auth_req_r, upd_busy_r, lock_s;
  logic              sel_s, wr_s, rd_s, start_s, abort_s, stg_wr_ok_s;
  logic [DEC_WD-1:0] offs_s;

  assign sel_s       = per_en & (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]);
  assign wr_s        = sel_s & (|per_we);
  assign rd_s        = sel_s & ~(|per_we);
  assign offs_s      = per_addr[DEC_WD-1:0];
  assign start_s     = wr_s & (offs_s == OFF_CTRL) & per_din[CTRL_START_BIT];
  assign abort_s     = wr_s & (offs_s == OFF_CTRL) & per_din[CTRL_ABORT_BIT];
  assign stg_wr_ok_s = wr_s & (state_r == ST_IDLE) & ~lock_s;

`ifdef CASU_ER_LOCK_EN
  logic lock_r;

  // Lock latches on the first commit and only reset clears it
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      lock_r <= 1'b0;
    end else if (state_r == ST_COMMIT) begin
      lock_r <= 1'b1;
    end else begin
      lock_r <= lock_r;
    end
  end

  assign lock_s = lock_r;
`else
  assign lock_s = 1'b0;
`endif

  casu_er_check u_check (
    .stg_min (stg_min_r),
    .stg_max (stg_max_r),
    .win_lo  (WIN_LO),
    .win_hi  (WIN_HI),
    .err     (chk_err_s)
  );

  // Staging registers, writable only while idle and unlocked
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      stg_min_r <= RST_MIN;
      stg_max_r <= RST_MAX;
    end else begin
      if (stg_wr_ok_s && (offs_s == OFF_STG_MIN)) stg_min_r <= per_din;
      if (stg_wr_ok_s && (offs_s == OFF_STG_MAX)) stg_max_r <= per_din;
    end
  end

  // Update sequencer; auth_req/upd_busy are registered alongside the state
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_r    <= ST_IDLE;
      er_min_r   <= RST_MIN;
      er_max_r   <= RST_MAX;
      err_r      <= ERR_NONE;
      done_r     <= 1'b0;
      to_cnt_r   <= 16'd0;
      auth_req_r <= 1'b0;
      upd_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            done_r <= 1'b0;
            if (lock_s) begin
              err_r <= ERR_LOCKED;
            end else begin
              err_r      <= ERR_NONE;
              state_r    <= ST_CHECK;
              upd_busy_r <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (chk_err_s != ERR_NONE) begin
            err_r      <= chk_err_s;
            state_r    <= ST_IDLE;
            upd_busy_r <= 1'b0;
          end else begin
            to_cnt_r   <= 16'd0;
            state_r    <= ST_WAIT_AUTH;
            auth_req_r <= 1'b1;
          end
        end
        ST_WAIT_AUTH: begin
          to_cnt_r <= to_cnt_r + 16'd1;
          if (auth_fail || abort_s || (!auth_ok && (to_cnt_r == TO_LAST))) begin
            err_r      <= auth_fail ? ERR_AUTH_FAIL : (abort_s ? ERR_ABORT : ERR_TIMEOUT);
            state_r    <= ST_IDLE;
            auth_req_r <= 1'b0;
            upd_busy_r <= 1'b0;
          end else if (auth_ok) begin
            state_r    <= ST_COMMIT;
            auth_req_r <= 1'b0;
          end
        end
        ST_COMMIT: begin
          er_min_r   <= stg_min_r;
          er_max_r   <= stg_max_r;
          done_r     <= 1'b1;
          state_r    <= ST_IDLE;
          upd_busy_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          auth_req_r <= 1'b0;
          upd_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Same-cycle register read mux
  always_comb begin
    per_dout = 16'h0000;
    if (rd_s) begin
      case (offs_s)
        OFF_STG_MIN: per_dout = stg_min_r;
        OFF_STG_MAX: per_dout = stg_max_r;
        OFF_STAT:    per_dout = pack_stat(state_r, err_r, done_r, auth_req_r, lock_s);
        default:     per_dout = 16'h0000;
      endcase
    end else begin
      per_dout = 16'h0000;
    end
  end

  assign auth_req = auth_req_r;
  assign upd_busy = upd_busy_r;
  assign ER_min   = er_min_r;
  assign ER_max   = er_max_r;

endmodule
